cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Two-port round-robin arbiter in front of the 2-way cache's single AXI4-Lite-style slave port (m_axi_* on the cache side).
- Requester 0 is the instruction fetch unit; requester 1 is the load/store unit.
- Each requester uses a simple req/done interface. The arbiter serialises their transactions onto the cache channels, with one transaction outstanding at a time.

Parameters:
FIRST_GRANT, 0, requester that wins the first simultaneous request after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  2  per-requester request; held high until done; bit i = requester i
we  in  2  1 = write, 0 = read; sampled at grant
addr  in  64  {addr1,addr0}, byte addresses, sampled at grant
wdata  in  64  {wdata1,wdata0}, sampled at grant
wstrb  in  8  {wstrb1,wstrb0}, sampled at grant
done  out  2  one-cycle completion pulse to the granted requester
rdata  out  32  read data, valid while done is high, shared by both requesters
err  out  2  response error, valid with done; equals resp[1]
busy  out  1  high whenever state != IDLE
grant  out  1  index of the requester currently being serviced
c_axi_araddr  out  32  to cache m_axi_araddr
c_axi_arvalid  out  1
c_axi_arready  in  1
c_axi_rdata  in  32
c_axi_rresp  in  2
c_axi_rvalid  in  1
c_axi_rready  out  1
c_axi_awaddr  out  32
c_axi_awvalid  out  1
c_axi_awready  in  1
c_axi_wdata  out  32
c_axi_wstrb  out  4
c_axi_wvalid  out  1
c_axi_wready  in  1
c_axi_bresp  in  2
c_axi_bvalid  in  1
c_axi_bready  out  1

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all valid/ready outputs 0, done 0, err 0, rdata 0, busy 0, state IDLE, last grant = ~FIRST_GRANT.
- Reset mid-transaction: the arbiter abandons the transaction with no completion pulse. The cache has no reset, so the system resets both blocks together.
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - Only one requester high: grant it.
  - Both high: grant ~last.
  - On grant, latch addr/wdata/wstrb/we of the winner into the c_axi_* address/data registers and set grant.
  - Read: arvalid <= 1, go to AR. Write: awvalid <= 1, go to AW.
  - Minimum latency: req sampled at edge t, valid high in cycle t+1.
- AR: hold arvalid and araddr stable until arvalid & arready. Then arvalid <= 0, rready <= 1, go to R.
  - The cache pulses arready for only one cycle while polling, so arvalid must never drop early.
- R: on rvalid & rready:
  - rready <= 0, rdata <= c_axi_rdata, err[g] <= rresp[1], done[g] <= 1.
  - Go to DONE.
- AW: hold awvalid until awready. Then awvalid <= 0, wvalid <= 1, go to W.
  - wvalid is never raised before AW completes, because the cache asserts wready only after accepting AW.
- W: hold wvalid, wdata and wstrb until wready. Then wvalid <= 0, bready <= 1, go to B.
- B: on bvalid & bready:
  - bready <= 0, err[g] <= bresp[1], done[g] <= 1, rdata unchanged.
  - Go to DONE.
- DONE:
  - done <= 0, last <= g, go to IDLE.
  - The requester must drop req at the edge ending the done cycle; IDLE therefore never re-grants a completed request.
- Requests arriving during service wait; no preemption and no timeout.
- Input changes after grant are ignored.
- done is never high on both bits. err is cleared to 0 in IDLE.
- Round-robin is strict alternation under continuous contention; a sole requester may be granted back-to-back.

Decomposition:
- Package cache_arb_pkg holds:
  - the state enum (IDLE..DONE),
  - AXI resp constants OKAY = 2'b00 and SLVERR = 2'b10,
  - the FIRST_GRANT default.
- The round-robin pick is a 2-input function inside the module. No sub-module.

Test Plan:
- p0 read addr 0x0000_0100; cache model returns 0xDEADBEEF, rresp 0 → araddr = 0x100, done = 2'b01 for exactly one cycle, rdata = 0xDEADBEEF, err = 0.
- Both requesters issue reads in the same cycle, repeated 4 times → grant order 0,1,0,1; done pulses alternate and the two never overlap.
- p1 write addr 0x0000_2000, wdata 0x1234_5678, wstrb 4'b0011 → awvalid precedes wvalid, awaddr = 0x2000, wstrb = 4'b0011, done = 2'b10 after bvalid.
- arready withheld 5 cycles, then pulsed 1 cycle → arvalid and araddr stable throughout; rready rises the cycle after the handshake.
- rresp = 2'b10 on a p0 read, then bresp = 2'b10 on a p1 write → err[0] = 1 and err[1] = 1 with their respective done pulses.
- rst asserted while in W → next cycle all valid/ready outputs 0, busy 0, no done pulse; a new request after reset is granted to FIRST_GRANT first.

Source files
------------

// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_arb_pkg
// Description : Shared types and constants for the two-port cache arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5,
        DONE = 3'd6
    } arb_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam bit FIRST_GRANT_DEFAULT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Round-robin arbiter serialising fetch and load/store requests
//               onto the cache's single AXI4-Lite-style slave port.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter bit FIRST_GRANT = FIRST_GRANT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic [1:0]  done,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic        busy,
    output logic        grant,
    output logic [31:0] c_axi_araddr,
    output logic        c_axi_arvalid,
    input  logic        c_axi_arready,
    input  logic [31:0] c_axi_rdata,
    input  logic [1:0]  c_axi_rresp,
    input  logic        c_axi_rvalid,
    output logic        c_axi_rready,
    output logic [31:0] c_axi_awaddr,
    output logic        c_axi_awvalid,
    input  logic        c_axi_awready,
    output logic [31:0] c_axi_wdata,
    output logic [3:0]  c_axi_wstrb,
    output logic        c_axi_wvalid,
    input  logic        c_axi_wready,
    input  logic [1:0]  c_axi_bresp,
    input  logic        c_axi_bvalid,
    output logic        c_axi_bready
);

    // Sole requester always wins; under contention the one not served last wins.
    function automatic logic pick_winner(input logic [1:0] r, input logic last);
        if (r == 2'b01)
            return 1'b0;
        else if (r == 2'b10)
            return 1'b1;
        else
            return ~last;
    endfunction

    arb_state_t  r_state;
    logic        r_last;
    logic [31:0] r_addr;

    logic        w_win;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_unused_resp_lsb;

    assign w_win   = pick_winner(req, r_last);
    assign w_we    = we[w_win];
    assign w_addr  = w_win ? addr[63:32]  : addr[31:0];
    assign w_wdata = w_win ? wdata[63:32] : wdata[31:0];
    assign w_wstrb = w_win ? wstrb[7:4]   : wstrb[3:0];

    assign w_unused_resp_lsb = c_axi_rresp[0] ^ c_axi_bresp[0];

    // Only one channel is ever active, so one address register feeds both.
    assign c_axi_araddr = r_addr;
    assign c_axi_awaddr = r_addr;
    assign busy         = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last        <= ~FIRST_GRANT;
            r_addr        <= '0;
            c_axi_arvalid <= 1'b0;
            c_axi_rready  <= 1'b0;
            c_axi_awvalid <= 1'b0;
            c_axi_wvalid  <= 1'b0;
            c_axi_bready  <= 1'b0;
            c_axi_wdata   <= '0;
            c_axi_wstrb   <= '0;
            done          <= '0;
            err           <= '0;
            rdata         <= '0;
            grant         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    err <= '0;
                    if (req != 2'b00) begin
                        grant       <= w_win;
                        r_addr      <= w_addr;
                        c_axi_wdata <= w_wdata;
                        c_axi_wstrb <= w_wstrb;
                        if (w_we) begin
                            c_axi_awvalid <= 1'b1;
                            r_state       <= AW;
                        end else begin
                            c_axi_arvalid <= 1'b1;
                            r_state       <= AR;
                        end
                    end
                end
                AR: begin
                    if (c_axi_arvalid && c_axi_arready) begin
                        c_axi_arvalid <= 1'b0;
                        c_axi_rready  <= 1'b1;
                        r_state       <= R;
                    end
                end
                R: begin
                    if (c_axi_rvalid && c_axi_rready) begin
                        c_axi_rready <= 1'b0;
                        rdata        <= c_axi_rdata;
                        err[grant]   <= c_axi_rresp[1];
                        done[grant]  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                AW: begin
                    if (c_axi_awvalid && c_axi_awready) begin
                        c_axi_awvalid <= 1'b0;
                        c_axi_wvalid  <= 1'b1;
                        r_state       <= W;
                    end
                end
                W: begin
                    if (c_axi_wvalid && c_axi_wready) begin
                        c_axi_wvalid <= 1'b0;
                        c_axi_bready <= 1'b1;
                        r_state      <= B;
                    end
                end
                B: begin
                    if (c_axi_bvalid && c_axi_bready) begin
                        c_axi_bready <= 1'b0;
                        err[grant]   <= c_axi_bresp[1];
                        done[grant]  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    done    <= '0;
                    r_last  <= grant;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
